// File: rtl/fetch_stage.sv
// IF stage + IF/ID register for the 5-stage RV32I core.
// Ports: clk/rst, StallF/StallD/FlushD, PCSrcE/PCTargetE/ALUResultE in;
// ImemAddrF/ImemRdataF/ImemReadyF imem port; PCF, PCD, PCPlus4D,
// InstrD, ValidD, FetchBusyF out.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  output logic [31:0] ImemAddrF,
  input  logic [31:0] ImemRdataF,
  input  logic        ImemReadyF,
  output logic [31:0] PCF,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic [31:0] InstrD,
  output logic        ValidD,
  output logic        FetchBusyF
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4d_q, pcp4d_d;
  logic [31:0] instrd_q, instrd_d;
  logic        validd_q, validd_d;
  logic        hold_pc;

  assign pc_plus4 = pc_q + 32'd4;
  assign hold_pc  = StallF | ~ImemReadyF;

  // Redirect beats stall and memory wait.
  always_comb begin
    pc_d = pc_q;
    unique case (PCSrcE)
      2'b00:   pc_d = hold_pc ? pc_q : pc_plus4;
      2'b01:   pc_d = PCTargetE;
      2'b10:   pc_d = {ALUResultE[31:1], 1'b0};
      default: pc_d = PCTargetE;
    endcase
  end

  always_comb begin
    pcd_d    = pcd_q;
    pcp4d_d  = pcp4d_q;
    instrd_d = instrd_q;
    validd_d = validd_q;
    if (FlushD || (!StallD && !ImemReadyF)) begin
      pcd_d    = '0;
      pcp4d_d  = '0;
      instrd_d = NOP_INSTR;
      validd_d = 1'b0;
    end else if (!StallD) begin
      pcd_d    = pc_q;
      pcp4d_d  = pc_plus4;
      instrd_d = ImemRdataF;
      validd_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      pcd_q    <= '0;
      pcp4d_q  <= '0;
      instrd_q <= NOP_INSTR;
      validd_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pcd_q    <= pcd_d;
      pcp4d_q  <= pcp4d_d;
      instrd_q <= instrd_d;
      validd_q <= validd_d;
    end
  end

  assign PCF        = pc_q;
  assign ImemAddrF  = pc_q;
  assign PCD        = pcd_q;
  assign PCPlus4D   = pcp4d_q;
  assign InstrD     = instrd_q;
  assign ValidD     = validd_q;
  assign FetchBusyF = ~ImemReadyF;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// Model + per-cycle compare + literal pins.
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, FlushD;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE, ALUResultE;
  logic [31:0] ImemAddrF, ImemRdataF;
  logic        ImemReadyF;
  logic [31:0] PCF, PCD, PCPlus4D, InstrD;
  logic        ValidD, FetchBusyF;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_pc, m_pcd, m_p4, m_ins;
  logic        m_v;

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign ImemRdataF = memw(ImemAddrF);

  fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ALUResultE(ALUResultE),
    .ImemAddrF(ImemAddrF), .ImemRdataF(ImemRdataF),
    .ImemReadyF(ImemReadyF),
    .PCF(PCF), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .InstrD(InstrD), .ValidD(ValidD),
    .FetchBusyF(FetchBusyF)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  // Reference behaviour: decode slot takes what was
  // fetched unless flushed/held/starved; PC follows
  // redirect, else advances when not held.
  always @(posedge clk) begin
    if (rst) begin
      m_pc = RPC; m_pcd = 0; m_p4 = 0;
      m_ins = NOP; m_v = 0;
    end else begin
      if (FlushD) begin
        m_pcd = 0; m_p4 = 0; m_ins = NOP; m_v = 0;
      end else if (StallD) begin
      end else if (!ImemReadyF) begin
        m_pcd = 0; m_p4 = 0; m_ins = NOP; m_v = 0;
      end else begin
        m_pcd = m_pc; m_p4 = m_pc + 4;
        m_ins = memw(m_pc); m_v = 1;
      end
      if (PCSrcE == 2'd1 || PCSrcE == 2'd3)
        m_pc = PCTargetE;
      else if (PCSrcE == 2'd2)
        m_pc = ALUResultE & 32'hFFFF_FFFE;
      else if (!StallF && ImemReadyF)
        m_pc = m_pc + 4;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("PCF", PCF, m_pc);
      chk("ImemAddrF", ImemAddrF, m_pc);
      chk("PCD", PCD, m_pcd);
      chk("PCPlus4D", PCPlus4D, m_p4);
      chk("InstrD", InstrD, m_ins);
      chk("ValidD", {31'd0, ValidD}, {31'd0, m_v});
      chk("FetchBusyF", {31'd0, FetchBusyF},
          {31'd0, ~ImemReadyF});
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    StallF = 0; StallD = 0; FlushD = 0;
    PCSrcE = 2'b00;
  endtask

  initial begin
    rst = 1; idle(); ImemReadyF = 1;
    PCTargetE = 0; ALUResultE = 0;
    step(); chk_en = 1'b1;
    step();
    chk("rst PCF", PCF, 32'h0);
    chk("rst InstrD", InstrD, NOP);
    chk("rst ValidD", {31'd0, ValidD}, 32'd0);
    rst = 0;
    // 1: sequential fetch
    step();
    chk("t1 PCF", PCF, 32'h4);
    chk("t1 InstrD", InstrD, 32'h BEEF_0000);
    chk("t1 ValidD", {31'd0, ValidD}, 32'd1);
    step();
    chk("t1 PCF8", PCF, 32'h8);
    // 2: stall
    StallF = 1; StallD = 1;
    step();
    chk("t2 PCF", PCF, 32'h8);
    chk("t2 PCD", PCD, 32'h4);
    idle();
    step();
    chk("t2 PCF C", PCF, 32'hC);
    chk("t2 PCD 8", PCD, 32'h8);
    // 3: branch redirect + flush
    PCSrcE = 2'b01; PCTargetE = 32'h100; FlushD = 1;
    step();
    chk("t3 PCF", PCF, 32'h100);
    chk("t3 InstrD", InstrD, NOP);
    chk("t3 ValidD", {31'd0, ValidD}, 32'd0);
    idle();
    step();
    chk("t3 PCD", PCD, 32'h100);
    chk("t3 ValidD1", {31'd0, ValidD}, 32'd1);
    // 4: jalr redirect with StallF
    PCSrcE = 2'b10; ALUResultE = 32'h205;
    StallF = 1; FlushD = 1;
    step();
    chk("t4 PCF", PCF, 32'h204);
    idle();
    step();
    chk("t4 PCD", PCD, 32'h204);
    // PCSrcE=11 acts as 01
    PCSrcE = 2'b11; PCTargetE = 32'h10; FlushD = 1;
    step();
    chk("t5 PCF", PCF, 32'h10);
    idle();
    // 5: memory wait
    ImemReadyF = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5 hold", PCF, 32'h10);
      chk("t5 bubble", {31'd0, ValidD}, 32'd0);
    end
    chk("t5 busy", {31'd0, FetchBusyF}, 32'd1);
    ImemReadyF = 1;
    step();
    chk("t5 PCD", PCD, 32'h10);
    chk("t5 InstrD", InstrD, 32'hBEFF_0010);
    step();
    chk("t5 nodup", PCD, 32'h14);
    // 6: wrap and reset in a wait
    PCSrcE = 2'b01; PCTargetE = 32'hFFFF_FFFC; FlushD = 1;
    step();
    idle();
    step();
    chk("t6 wrap", PCF, 32'h0);
    chk("t6 p4", PCPlus4D, 32'h0);
    chk("t6 PCD", PCD, 32'hFFFF_FFFC);
    step();
    ImemReadyF = 0;
    step();
    rst = 1; PCSrcE = 2'b01; PCTargetE = 32'h80;
    step();
    chk("t6 rst PCF", PCF, RPC);
    chk("t6 rst V", {31'd0, ValidD}, 32'd0);
    rst = 0; idle(); ImemReadyF = 1;
    step();
    chk("t6 PCF4", PCF, 32'h4);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
